// File: rtl/fake_netlist_pkg.sv
// Shared types, widths and step functions for the benchmark-netlist pattern driver.
// Consumed by pattern_lfsr7 and fake_netlist_pattern_driver.
package fake_netlist_pkg;

  localparam int unsigned PAT_W = 7;
  localparam int unsigned SIG_W = 16;

  // x^7 + x^6 + 1: feedback is l[6] ^ l[5]
  localparam logic [PAT_W-1:0] LFSR7_TAPS = 7'b1100000;
  localparam logic [SIG_W-1:0] SIG_POLY   = 16'h1021;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCapture,
    StDone
  } state_e;

  function automatic logic [PAT_W-1:0] lfsr7_next(input logic [PAT_W-1:0] l);
    return {l[PAT_W-2:0], ^(l & LFSR7_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig, input logic resp);
    logic fb;
    fb = sig[SIG_W-1] ^ resp;
    return {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
  endfunction

endpackage

// File: rtl/pattern_lfsr7.sv
// 7-bit maximal-length Fibonacci LFSR with synchronous seed load and advance.
module pattern_lfsr7
  import fake_netlist_pkg::*;
#(
  parameter logic [PAT_W-1:0] ResetVal = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [PAT_W-1:0] seed_i,
  output logic [PAT_W-1:0] state_o
);

  logic [PAT_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (advance_i) begin
      lfsr_d = lfsr7_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= ResetVal;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fake_netlist_pattern_driver.sv
// Drives LFSR vectors into a 7-in/1-out netlist and folds its response into a 16-bit signature.
// Optional macro PATTERN_DRIVER_ZERO_VEC_EN: first vector of each run is all-zero.
module fake_netlist_pattern_driver
  import fake_netlist_pkg::*;
#(
  parameter int unsigned      NUM_PATTERNS  = 127,
  parameter logic [PAT_W-1:0] SEED          = 7'h01,
  parameter int unsigned      SETTLE_CYCLES = 1,
  parameter logic [SIG_W-1:0] SIG_INIT      = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic [PAT_W-1:0] pattern_o,
  input  logic             resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] signature_o,
  output logic [15:0]      pattern_count_o
);

  // An all-zero seed would lock the LFSR up
  localparam logic [PAT_W-1:0] SeedEff    = (SEED == '0) ? 7'h01 : SEED;
  localparam int unsigned      SettleEff  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [15:0]      SettleLast = 16'(SettleEff - 1);
  localparam logic [15:0]      NumPat     = 16'(NUM_PATTERNS);

`ifdef PATTERN_DRIVER_ZERO_VEC_EN
  localparam logic [PAT_W-1:0] FirstVec = '0;
`else
  localparam logic [PAT_W-1:0] FirstVec = SeedEff;
`endif

  state_e           state_q, state_d;
  logic [15:0]      settle_q, settle_d;
  logic [15:0]      count_q, count_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             lfsr_load, lfsr_adv;
  logic [PAT_W-1:0] lfsr_state;

  pattern_lfsr7 #(
    .ResetVal (SeedEff)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (lfsr_load),
    .advance_i (lfsr_adv),
    .seed_i    (SeedEff),
    .state_o   (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    count_d   = count_q;
    sig_d     = sig_q;
    pat_d     = pat_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          lfsr_load = 1'b1;
          pat_d     = FirstVec;
          sig_d     = SIG_INIT;
          count_d   = '0;
          settle_d  = '0;
          state_d   = StDrive;
        end
      end
      StDrive: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StCapture;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      StCapture: begin
        sig_d   = sig_step(sig_q, resp_i);
        count_d = count_q + 16'd1;
`ifdef PATTERN_DRIVER_ZERO_VEC_EN
        // After the zero vector the LFSR still holds the seed, so present it unadvanced
        if (count_q == '0) begin
          pat_d = lfsr_state;
        end else begin
          lfsr_adv = 1'b1;
          pat_d    = lfsr7_next(lfsr_state);
        end
`else
        lfsr_adv = 1'b1;
        pat_d    = lfsr7_next(lfsr_state);
`endif
        state_d = (count_d == NumPat) ? StDone : StDrive;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      count_q  <= '0;
      sig_q    <= '0;
      pat_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
      pat_q    <= pat_d;
    end
  end

  assign pattern_o       = pat_q;
  assign busy_o          = (state_q == StDrive) || (state_q == StCapture);
  assign done_o          = (state_q == StDone);
  assign signature_o     = sig_q;
  assign pattern_count_o = count_q;

endmodule
